// File: rtl/video_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : video_fifo_pkg                                                   |
// | Brief   : Shared constants, clog2 helper and pointer typing for the video  |
// |           line FIFO family.                                                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package video_fifo_pkg;

    localparam int MIN_DEPTH = 4;
    localparam int MAX_DEPTH = 1024;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Pointers carry one extra wrap bit above the index bits.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    typedef logic [ptr_w(MAX_DEPTH)-1:0] ptr_max_t;

endpackage
`default_nettype wire

// File: rtl/video_fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : video_fifo_ram                                                   |
// | Brief   : DEPTH x WIDTH register array, synchronous write, async read.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module video_fifo_ram
    import video_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       i_wr_en,
    input  logic [clog2(DEPTH)-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic [clog2(DEPTH)-1:0]    i_rd_addr,
    output logic [WIDTH-1:0]           o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/video_line_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : video_line_fifo                                                  |
// | Brief   : First-word-fall-through pixel FIFO with valid/ready on both      |
// |           sides, registered occupancy and status flags. Defining          |
// |           VIDEO_FIFO_ERR_EN adds sticky ovf_err/unf_err outputs.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module video_line_fifo
    import video_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic [clog2(DEPTH):0]      count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full
`ifdef VIDEO_FIFO_ERR_EN
    ,
    output logic                       ovf_err,
    output logic                       unf_err
`endif
);

    localparam int c_addr_w = clog2(DEPTH);
    localparam int c_ptr_w  = ptr_w(DEPTH);

    typedef logic [c_ptr_w-1:0] ptr_t;

    ptr_t             r_wr_ptr;
    ptr_t             r_rd_ptr;
    ptr_t             r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;

    ptr_t             w_wr_ptr_nxt;
    ptr_t             w_rd_ptr_nxt;
    ptr_t             w_count_nxt;
    logic             w_full_nxt;
    logic             w_empty_nxt;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [WIDTH-1:0] w_ram_rd_data;

    assign w_wr_fire = wr_valid & ~r_full;
    assign w_rd_fire = rd_ready & ~r_empty;

    // Flags are computed from the post-edge pointers so they land registered.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + ptr_t'(w_wr_fire);
        w_rd_ptr_nxt = r_rd_ptr + ptr_t'(w_rd_fire);
        w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
        w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_full_nxt   = (w_wr_ptr_nxt[c_addr_w-1:0] == w_rd_ptr_nxt[c_addr_w-1:0]) &&
                       (w_wr_ptr_nxt[c_addr_w] != w_rd_ptr_nxt[c_addr_w]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_count       <= w_count_nxt;
            r_full        <= w_full_nxt;
            r_empty       <= w_empty_nxt;
            r_almost_full <= (w_count_nxt >= ptr_t'(AF_LEVEL));
        end
    end

    video_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_fire),
        .i_wr_addr (r_wr_ptr[c_addr_w-1:0]),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_ptr[c_addr_w-1:0]),
        .o_rd_data (w_ram_rd_data)
    );

    assign wr_ready    = ~r_full;
    assign rd_valid    = ~r_empty;
    assign rd_data     = r_empty ? '0 : w_ram_rd_data;
    assign count       = r_count;
    assign full        = r_full;
    assign empty       = r_empty;
    assign almost_full = r_almost_full;

`ifdef VIDEO_FIFO_ERR_EN
    logic r_ovf_err;
    logic r_unf_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            r_ovf_err <= r_ovf_err | (wr_valid & r_full);
            r_unf_err <= r_unf_err | (rd_ready & r_empty);
        end
    end

    assign ovf_err = r_ovf_err;
    assign unf_err = r_unf_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_line_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_video_line_fifo                                               |
// | Brief   : Scoreboard bench for video_line_fifo at WIDTH=8, DEPTH=16,       |
// |           AF_LEVEL=12; error flags are checked when VIDEO_FIFO_ERR_EN set.|
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_video_line_fifo;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
`ifdef VIDEO_FIFO_ERR_EN
    logic       ovf_err;
    logic       unf_err;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb[$];

    video_line_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
`ifdef VIDEO_FIFO_ERR_EN
        ,
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every read handshake must deliver the oldest outstanding write.
    always @(negedge clk) begin
        if (rst === 1'b0 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read data", rd_data);
            end else begin
                check("rd_data", {24'h0, rd_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        check("rst_count",    32'(count),       32'd0);
        check("rst_empty",    32'(empty),       32'd1);
        check("rst_full",     32'(full),        32'd0);
        check("rst_wr_ready", 32'(wr_ready),    32'd1);
        check("rst_rd_valid", 32'(rd_valid),    32'd0);
        check("rst_rd_data",  32'(rd_data),     32'd0);
        check("rst_af",       32'(almost_full), 32'd0);
`ifdef VIDEO_FIFO_ERR_EN
        check("rst_ovf", 32'(ovf_err), 32'd0);
        check("rst_unf", 32'(unf_err), 32'd0);
`endif

        // Fill 0x00..0x0F; almost_full rises with the 12th write.
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            sb.push_back(8'(i));
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
        end
        wr_data = 8'hAA;
        tick();
        wr_valid = 1'b0;
        check("ovf_count",    32'(count),    32'd16);
        check("ovf_full",     32'(full),     32'd1);
        check("ovf_wr_ready", 32'(wr_ready), 32'd0);
`ifdef VIDEO_FIFO_ERR_EN
        check("ovf_err", 32'(ovf_err), 32'd1);
`endif

        rd_ready = 1'b1;
        repeat (16) tick();
        check("drain_empty",    32'(empty),    32'd1);
        check("drain_rd_valid", 32'(rd_valid), 32'd0);
        check("drain_rd_data",  32'(rd_data),  32'd0);
        check("drain_count",    32'(count),    32'd0);
        tick();
        rd_ready = 1'b0;
`ifdef VIDEO_FIFO_ERR_EN
        check("unf_err", 32'(unf_err), 32'd1);
`endif

        // Preload 8, then stream 40 concurrent write/read pairs across the wraps.
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + i);
            sb.push_back(wr_data);
            tick();
        end
        check("preload_count", 32'(count), 32'd8);
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'(8'h18 + i);
            sb.push_back(wr_data);
            tick();
            check("stream_count", 32'(count), 32'd8);
        end
        wr_valid = 1'b0;
        repeat (8) tick();
        rd_ready = 1'b0;
        check("stream_empty", 32'(empty), 32'd1);

        // Full with simultaneous write and read: read wins, write retries.
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h60 + i);
            sb.push_back(wr_data);
            tick();
        end
        check("fs_full", 32'(full), 32'd1);
        wr_data  = 8'h55;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("fs_count_15", 32'(count),    32'd15);
        check("fs_wr_ready", 32'(wr_ready), 32'd1);
        sb.push_back(8'h55);
        tick();
        wr_valid = 1'b0;
        check("fs_count_16", 32'(count), 32'd16);
        check("fs_full2",    32'(full),  32'd1);
        rd_ready = 1'b1;
        repeat (16) tick();
        rd_ready = 1'b0;
        check("fs_empty", 32'(empty), 32'd1);

        // Reset with a pending write discards everything.
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h70 + i);
            sb.push_back(wr_data);
            tick();
        end
        check("pre_rst_count", 32'(count), 32'd9);
        rst     = 1'b1;
        wr_data = 8'h99;
        tick();
        rst      = 1'b0;
        wr_valid = 1'b0;
        sb.delete();
        check("mid_rst_count",    32'(count),    32'd0);
        check("mid_rst_empty",    32'(empty),    32'd1);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        sb.push_back(8'h3C);
        tick();
        wr_valid = 1'b0;
        check("post_rst_rd_valid", 32'(rd_valid), 32'd1);
        check("post_rst_rd_data",  32'(rd_data),  32'h3C);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("post_rst_empty", 32'(empty),     32'd1);
        check("sb_drained",     32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
